// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- bundle of pipeline-control signals between the core
// (pipeline datapath, hazard unit, debug unit) and the PC sequencer.
//   master : the core side; drives PC/redirect/hazard/debug inputs and
//            observes the sequencer's control outputs.
//   slave  : the sequencer; consumes the inputs, drives next_pc, pc_stall,
//            flush_if_id, flush_id_ex, pipe_enable, state, done, cycle_count.
interface pc_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  // Core -> sequencer
  logic [DATA_WIDTH-1:0] pc_i;
  logic                  hazard_stall;
  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  jump;
  logic [DATA_WIDTH-1:0] jump_target;
  logic                  halt_detected;
  logic                  dbg_run;
  logic                  dbg_step;
  logic                  dbg_halt;

  // Sequencer -> core
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  pc_stall;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic                  pipe_enable;
  logic [2:0]            state;
  logic                  done;
  logic [31:0]           cycle_count;

  modport master (
    output pc_i, hazard_stall, branch_taken, branch_target, jump, jump_target,
           halt_detected, dbg_run, dbg_step, dbg_halt,
    input  next_pc, pc_stall, flush_if_id, flush_id_ex, pipe_enable, state,
           done, cycle_count
  );

  modport slave (
    input  pc_i, hazard_stall, branch_taken, branch_target, jump, jump_target,
           halt_detected, dbg_run, dbg_step, dbg_halt,
    output next_pc, pc_stall, flush_if_id, flush_id_ex, pipe_enable, state,
           done, cycle_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- run-control FSM and next-PC selection for an in-order
// pipeline. Starts idle, runs or single-steps on debug commands, drains the
// pipeline after a HALT fetch and then parks in HALTED until reset.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : pc_sequencer_if.slave (PC/redirect/hazard/debug inputs,
//            next_pc/stall/flush/enable/state/done/cycle_count outputs)
// Parameters:
//   DATA_WIDTH   : PC and target width
//   DRAIN_CYCLES : cycles spent in DRAIN after an accepted HALT (>=1)
module pc_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state_q;
  logic [CW-1:0] drain_cnt_q;
  logic          done_q;
  logic [31:0]   cycle_cnt_q;

  logic active;       // pipeline advances this cycle
  logic fetching;     // PC may load this cycle (RUN/STEP)
  logic issue_stall;  // load-use stall not overridden by a taken branch
  logic halt_accept;  // HALT in IF that is not squashed or stalled

  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first); otherwise synthesis infers a latch.
  always_comb begin
    active      = 1'b0;
    fetching    = 1'b0;
    if (!reset) begin
      active   = (state_q == RUN) || (state_q == STEP) || (state_q == DRAIN);
      fetching = (state_q == RUN) || (state_q == STEP);
    end
    issue_stall = bus.hazard_stall & ~bus.branch_taken;
    halt_accept = bus.halt_detected & ~issue_stall & ~bus.branch_taken & ~bus.jump;
  end

  // A taken branch in EX beats a jump decoded in ID (it is older).
  assign bus.next_pc     = bus.branch_taken ? bus.branch_target :
                           bus.jump         ? bus.jump_target   :
                                              bus.pc_i + DATA_WIDTH'(4);
  // Outside RUN/STEP (and throughout reset) the PC is frozen.
  assign bus.pc_stall    = fetching ? issue_stall : 1'b1;
  assign bus.pipe_enable = active;
  assign bus.flush_if_id = (bus.branch_taken | bus.jump) & active;
  assign bus.flush_id_ex = bus.branch_taken & active;
  assign bus.state       = state_q;
  assign bus.done        = done_q;
  assign bus.cycle_count = cycle_cnt_q;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      if (active && (cycle_cnt_q != '1)) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end

      case (state_q)
        IDLE: begin
          if (bus.dbg_run) begin
            state_q <= RUN;
          end else if (bus.dbg_step) begin
            state_q <= STEP;
          end
        end

        RUN, STEP: begin
          if (bus.dbg_halt) begin
            state_q <= IDLE;
          end else if (halt_accept) begin
            state_q     <= DRAIN;
            drain_cnt_q <= CW'(DRAIN_CYCLES - 1);
          end else if ((state_q == STEP) && !issue_stall) begin
            // The single advance cycle of a step has just happened.
            state_q <= IDLE;
          end
        end

        DRAIN: begin
          // A late taken branch means the HALT was on a wrong path.
          if (bus.branch_taken) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
          end else if (drain_cnt_q == '0) begin
            state_q <= HALTED;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - CW'(1);
          end
        end

        HALTED: begin
          state_q <= HALTED;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, PC/target width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, cycles from HALT fetch to pipeline empty (>=1).
REQ-003 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have pc_i  input  DATA_WIDTH  current PC register value.
REQ-006 SHALL have hazard_stall  input  1  load-use stall request from hazard unit.
REQ-007 SHALL have branch_taken / branch_target  input  1 / DATA_WIDTH  resolved taken branch from EX.
REQ-008 SHALL have jump / jump_target  input  1 / DATA_WIDTH  jump decoded in ID.
REQ-009 SHALL have halt_detected  input  1  HALT opcode present in IF.
REQ-010 SHALL have dbg_run, dbg_step, dbg_halt  input  1 each  debug-unit commands, single-cycle pulses.
REQ-011 SHALL have next_pc  output  DATA_WIDTH  value the PC loads when not stalled.
REQ-012 SHALL have pc_stall  output  1  holds the PC register.
REQ-013 SHALL have flush_if_id, flush_id_ex  output  1 each  bubble insertion into those pipeline registers.
REQ-014 SHALL have pipe_enable  output  1  global pipeline advance enable.
REQ-015 SHALL have state  output  3  encoded FSM state; done  output  1  program finished.
REQ-016 SHALL have cycle_count  output  32  executed-cycle counter.

Function
REQ-017 SHALL implement states IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
REQ-018 next_pc SHALL be combinational: branch_taken ? branch_target : jump ? jump_target : pc_i+4 (modulo 2^DATA_WIDTH; 0xFFFFFFFC wraps to 0).
REQ-019 pipe_enable SHALL be 1 in RUN, STEP, DRAIN; 0 in IDLE, HALTED.
REQ-020 flush_if_id SHALL be (branch_taken|jump)&pipe_enable; flush_id_ex SHALL be branch_taken&pipe_enable.
REQ-021 pc_stall SHALL be 1 in IDLE, HALTED, DRAIN; in RUN/STEP SHALL equal hazard_stall&~branch_taken (taken branch overrides load-use stall).
REQ-022 IDLE: dbg_run -> RUN; dbg_step (without dbg_run) -> STEP; dbg_run with dbg_step -> RUN.
REQ-023 STEP: one cycle with pc_stall=0 SHALL occur, then -> IDLE; while hazard_stall&~branch_taken, STEP SHALL persist.
REQ-024 RUN: dbg_halt -> IDLE (highest priority); else halt_detected&~pc_stall&~branch_taken&~jump -> DRAIN, counter loaded DRAIN_CYCLES-1; halt_detected squashed by redirect SHALL be ignored.
REQ-025 STEP SHALL apply the REQ-024 halt rule identically.
REQ-026 DRAIN: counter decrements each cycle; at counter 0 -> HALTED; branch_taken in DRAIN SHALL cancel drain -> RUN with redirect; dbg_halt in DRAIN SHALL be ignored.
REQ-027 HALTED: done=1, held until reset; all commands and redirects ignored.
REQ-028 cycle_count SHALL increment every cycle pipe_enable=1, saturating at 0xFFFFFFFF.
REQ-029 In IDLE/HALTED, branch_taken, jump, hazard_stall SHALL produce no flush and no state change.

Reset
REQ-030 reset SHALL force state=IDLE, drain counter=0, cycle_count=0, done=0, regardless of current state (including mid-DRAIN or STEP).
REQ-031 During and after reset, pc_stall=1, pipe_enable=0, flushes=0 until a dbg_run/dbg_step.

Verification
REQ-032 Reset, dbg_run, pc_i=0x100, no events -> state=1, next_pc=0x104, pc_stall=0, cycle_count increments 1/cycle.
REQ-033 RUN, hazard_stall=1 with branch_taken=1, branch_target=0x40 -> next_pc=0x40, pc_stall=0, flush_if_id=1, flush_id_ex=1.
REQ-034 RUN, halt_detected=1 -> DRAIN for exactly 4 cycles (pc_stall=1), then HALTED, done=1; dbg_run afterwards -> no change.
REQ-035 DRAIN cycle 2, branch_taken=1, target=0x200 -> state=RUN next cycle, next_pc=0x200; pc_i=0xFFFFFFFC no redirect -> next_pc=0.
REQ-036 IDLE, dbg_step with hazard_stall=1 for 2 cycles -> STEP held 2 cycles, one advance cycle, back to IDLE; reset asserted in DRAIN -> IDLE, cycle_count=0.
